mul_iter: RTL and testbench



---
 rtl/mul_iter_pkg.sv | 44 ++++
 rtl/mul_partial.sv | 34 +++
 rtl/mul_iter.sv | 171 +++++++++++++++++
 tb/tb_mul_iter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_iter_pkg.sv
// -----------------------------------------------------------------------------
// mul_iter_pkg
//   Shared types and helpers for the iterative RV32M multiply unit.
//   - mul_op_e    : RV32M multiply operation, 2-bit encoding as driven on op_i
//   - mul_state_e : sequencing states of the iterative multiplier
//   - op_a_signed / op_b_signed : per-operand signedness for an operation
//   - is_pp_state : true in the four partial-product states
// -----------------------------------------------------------------------------
package mul_iter_pkg;

   localparam int XLEN = 32;
   localparam int HALF = XLEN / 2;

   typedef enum logic [1:0] {
      OP_MUL    = 2'b00,
      OP_MULH   = 2'b01,
      OP_MULHSU = 2'b10,
      OP_MULHU  = 2'b11
   } mul_op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PP0  = 3'd1,
      ST_PP1  = 3'd2,
      ST_PP2  = 3'd3,
      ST_PP3  = 3'd4,
      ST_DONE = 3'd5
   } mul_state_e;

   // rs1 is treated as signed for MULH and MULHSU.
   function automatic logic op_a_signed(input mul_op_e op);
      return (op == OP_MULH) || (op == OP_MULHSU);
   endfunction

   // rs2 is treated as signed for MULH only.
   function automatic logic op_b_signed(input mul_op_e op);
      return (op == OP_MULH);
   endfunction

   function automatic logic is_pp_state(input mul_state_e st);
      return (st == ST_PP0) || (st == ST_PP1) || (st == ST_PP2) || (st == ST_PP3);
   endfunction

endpackage

// File: rtl/mul_partial.sv
// -----------------------------------------------------------------------------
// mul_partial
//   Combinational 16x16 multiplier with independent signed flags per operand.
//   Each operand is widened to 17 bits (sign bit or zero) so one signed
//   multiplier covers unsigned, signed and mixed products.
//   Ports:
//     a_i, b_i               16-bit operand halves
//     a_signed_i, b_signed_i treat the corresponding operand as two's complement
//     prod_o                 32-bit product; two's complement when either
//                            operand is signed, otherwise unsigned
// -----------------------------------------------------------------------------
module mul_partial
   import mul_iter_pkg::*;
(
   input  logic [HALF-1:0] a_i,
   input  logic [HALF-1:0] b_i,
   input  logic            a_signed_i,
   input  logic            b_signed_i,
   output logic [XLEN-1:0] prod_o
);

   logic signed [HALF:0]   a_ext;
   logic signed [HALF:0]   b_ext;
   logic signed [XLEN-1:0] prod;

   assign a_ext = $signed({a_signed_i & a_i[HALF-1], a_i});
   assign b_ext = $signed({b_signed_i & b_i[HALF-1], b_i});

   // Every 17x17 product of these ranges fits in 32 bits (signed when either
   // side is signed, unsigned otherwise), so computing modulo 2^32 is exact.
   assign prod   = a_ext * b_ext;
   assign prod_o = prod;

endmodule

// File: rtl/mul_iter.sv
// -----------------------------------------------------------------------------
// mul_iter
//   Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU). The 32x32 product is
//   built from four 16x16 partial products, one per cycle, on a single shared
//   mul_partial instance, summed into a 64-bit accumulator. MUL stops after
//   three partials since aH*bH only affects bits [63:32].
//   Ports:
//     clk, reset_n   clock (rising edge), asynchronous active-low reset
//     start_i        request, sampled only while not busy
//     op_i           00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//     rs1_i, rs2_i   operands, latched on the accepting edge
//     flush_i        abort an in-progress operation (no result)
//     busy_o         high in the partial-product states
//     done_o         one-cycle pulse when result_o is updated
//     result_o       registered result, held until the next done_o
// -----------------------------------------------------------------------------
module mul_iter
   import mul_iter_pkg::*;
(
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   mul_state_e        state_q, state_d;
   mul_op_e           op_q;
   logic [XLEN-1:0]   rs1_q, rs2_q;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   result_q;
   logic              busy_q, done_q;

   logic              sa, sb;
   logic              in_pp;
   logic [HALF-1:0]   pp_a, pp_b;
   logic              pp_a_signed, pp_b_signed;
   logic [XLEN-1:0]   pp;
   logic [2*XLEN-1:0] pp_ext, pp_shifted;

   assign sa    = op_a_signed(op_q);
   assign sb    = op_b_signed(op_q);
   assign in_pp = is_pp_state(state_q);

   // ---------------------------------------------------------------------------
   // Operand selection for the shared partial-product multiplier.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of a combinational block gets a default before the
      // case so no path leaves it unassigned (which would infer a latch).
      pp_a        = rs1_q[HALF-1:0];
      pp_b        = rs2_q[HALF-1:0];
      pp_a_signed = 1'b0;
      pp_b_signed = 1'b0;
      case (state_q)
         ST_PP1: begin
            pp_b        = rs2_q[XLEN-1:HALF];
            pp_b_signed = sb;
         end
         ST_PP2: begin
            pp_a        = rs1_q[XLEN-1:HALF];
            pp_a_signed = sa;
         end
         ST_PP3: begin
            pp_a        = rs1_q[XLEN-1:HALF];
            pp_b        = rs2_q[XLEN-1:HALF];
            pp_a_signed = sa;
            pp_b_signed = sb;
         end
         default: ;
      endcase
   end

   mul_partial u_partial (
      .a_i        (pp_a),
      .b_i        (pp_b),
      .a_signed_i (pp_a_signed),
      .b_signed_i (pp_b_signed),
      .prod_o     (pp)
   );

   // ---------------------------------------------------------------------------
   // Accumulation: extend the partial to 64 bits, align it, add (mod 2^64).
   // ---------------------------------------------------------------------------
   always_comb begin
      if (pp_a_signed || pp_b_signed) begin
         pp_ext = {{XLEN{pp[XLEN-1]}}, pp};
      end else begin
         pp_ext = {{XLEN{1'b0}}, pp};
      end

      case (state_q)
         ST_PP1, ST_PP2: pp_shifted = pp_ext << HALF;
         ST_PP3:         pp_shifted = pp_ext << XLEN;
         default:        pp_shifted = pp_ext;
      endcase

      acc_d = acc_q + pp_shifted;
   end

   // ---------------------------------------------------------------------------
   // Next-state logic. Flush wins over everything in the partial-product
   // states and also blocks a start in IDLE/DONE.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE,
         ST_DONE: state_d = (start_i && !flush_i) ? ST_PP0 : ST_IDLE;
         ST_PP0:  state_d = ST_PP1;
         ST_PP1:  state_d = ST_PP2;
         ST_PP2:  state_d = (op_q == OP_MUL) ? ST_DONE : ST_PP3;
         ST_PP3:  state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase

      if (in_pp && flush_i) begin
         state_d = ST_IDLE;
      end
   end

   // ---------------------------------------------------------------------------
   // State, datapath and registered outputs.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the operand latches are reset along with the control state so
         // the whole unit comes out of reset in a known, repeatable condition.
         state_q  <= ST_IDLE;
         op_q     <= OP_MUL;
         rs1_q    <= '0;
         rs2_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         // NOTE: all sequential state uses non-blocking assignments so every
         // register samples the pre-edge values regardless of statement order.
         state_q <= state_d;
         busy_q  <= is_pp_state(state_d);
         done_q  <= (state_d == ST_DONE);

         if (state_d == ST_PP0) begin
            // Accept: PP0 is only ever entered from IDLE/DONE on a start.
            op_q  <= mul_op_e'(op_i);
            rs1_q <= rs1_i;
            rs2_q <= rs2_i;
            acc_q <= '0;
         end else if (in_pp) begin
            acc_q <= acc_d;
         end

         // DONE is only reached from PP2/PP3, so acc_d already holds the
         // final partial sum on this edge.
         if (state_d == ST_DONE) begin
            result_q <= (op_q == OP_MUL) ? acc_d[XLEN-1:0] : acc_d[2*XLEN-1:XLEN];
         end
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign result_o = result_q;

endmodule

// File: tb/tb_mul_iter.sv
// -----------------------------------------------------------------------------
// tb_mul_iter
//   Directed bench for mul_iter: a table of hand-computed products checked for
//   value, latency and busy length, followed by sequences for ignored starts,
//   flush, mid-operation reset and back-to-back operations.
// -----------------------------------------------------------------------------
module tb_mul_iter;
   import mul_iter_pkg::*;

   logic        clk     = 1'b0;
   logic        reset_n = 1'b0;
   logic        start_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [1:0]  op_i    = 2'b00;
   logic [31:0] rs1_i   = '0;
   logic [31:0] rs2_i   = '0;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mul_iter dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start_i  (start_i),
      .op_i     (op_i),
      .rs1_i    (rs1_i),
      .rs2_i    (rs2_i),
      .flush_i  (flush_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .result_o (result_o)
   );

   typedef struct {
      mul_op_e     op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Presents a request for one clock and returns at the falling edge of the
   // first cycle after the accepting edge (cycle t+1). Inputs are scrambled
   // afterwards so any use of live operands shows up.
   task automatic start_op(input mul_op_e op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start_i = 1'b1;
      op_i    = op;
      rs1_i   = a;
      rs2_i   = b;
      @(negedge clk);
      start_i = 1'b0;
      op_i    = ~op;
      rs1_i   = $urandom;
      rs2_i   = $urandom;
   endtask

   // Samples outputs at falling edges k = 1..ncyc (k=1 is the current edge).
   task automatic observe(input int ncyc, output int first_done, output int n_done,
                          output int n_busy, output logic [31:0] res);
      first_done = 0;
      n_done     = 0;
      n_busy     = 0;
      res        = '0;
      for (int k = 1; k <= ncyc; k++) begin
         if (busy_o) n_busy++;
         if (done_o) begin
            n_done++;
            if (first_done == 0) begin
               first_done = k;
               res        = result_o;
            end
         end
         if (k < ncyc) @(negedge clk);
      end
   endtask

   // Watchdog: the bench is a few hundred cycles; anything longer is a hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          fd, nd, nb;
      int          exp_lat;
      logic [31:0] res;
      logic [31:0] last_res;
      int          dk [2];
      logic [31:0] dr [2];

      vecs[0]  = '{OP_MUL,    32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
      vecs[1]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[2]  = '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[4]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      vecs[5]  = '{OP_MUL,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
      vecs[6]  = '{OP_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
      vecs[7]  = '{OP_MULHSU, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF};
      vecs[8]  = '{OP_MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};
      vecs[9]  = '{OP_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780};
      vecs[10] = '{OP_MULHU,  32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E};
      vecs[11] = '{OP_MULH,   32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF};

      // Reset state.
      repeat (2) @(negedge clk);
      check("reset busy_o", {31'b0, busy_o}, 32'd0);
      check("reset done_o", {31'b0, done_o}, 32'd0);
      check("reset result_o", result_o, 32'd0);
      reset_n = 1'b1;

      // Table of single operations: value, latency, busy length, single pulse.
      for (int i = 0; i < NV; i++) begin
         exp_lat = (vecs[i].op == OP_MUL) ? 4 : 5;
         start_op(vecs[i].op, vecs[i].a, vecs[i].b);
         observe(8, fd, nd, nb, res);
         check($sformatf("vec%0d result", i), res, vecs[i].exp);
         check($sformatf("vec%0d done latency", i), fd, exp_lat);
         check($sformatf("vec%0d busy cycles", i), nb, exp_lat - 1);
         check($sformatf("vec%0d done pulses", i), nd, 32'd1);
         check($sformatf("vec%0d result held", i), result_o, vecs[i].exp);
      end
      last_res = vecs[NV-1].exp;

      // Second start while busy is ignored; latched operands are used.
      start_op(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
      start_i = 1'b1;
      op_i    = OP_MUL;
      rs1_i   = 32'd3;
      rs2_i   = 32'd5;
      @(negedge clk);
      start_i = 1'b0;
      observe(9, fd, nd, nb, res);
      check("ignored-start result", res, 32'h0B00_EA4E);
      check("ignored-start done latency", fd + 1, 32'd5);
      check("ignored-start done pulses", nd, 32'd1);
      last_res = 32'h0B00_EA4E;

      // Flush during PP1 of a MULH: no done, result held, then a fresh MUL.
      start_op(OP_MULH, 32'h8000_0000, 32'h8000_0000);
      @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      check("flush busy_o dropped", {31'b0, busy_o}, 32'd0);
      observe(6, fd, nd, nb, res);
      check("flush done pulses", nd, 32'd0);
      check("flush result held", result_o, last_res);
      start_op(OP_MUL, 32'd3, 32'd5);
      observe(8, fd, nd, nb, res);
      check("post-flush MUL result", res, 32'h0000_000F);
      check("post-flush MUL latency", fd, 32'd4);

      // Reset asserted in cycle t+3 of a MULHU: outputs clear at once.
      start_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("mid-op reset busy_o", {31'b0, busy_o}, 32'd0);
      check("mid-op reset done_o", {31'b0, done_o}, 32'd0);
      check("mid-op reset result_o", result_o, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      observe(6, fd, nd, nb, res);
      check("mid-op reset done pulses", nd, 32'd0);

      // Back-to-back: MULHU started in the DONE cycle of a MUL.
      dk[0] = 0; dk[1] = 0;
      dr[0] = '0; dr[1] = '0;
      nd    = 0;
      start_op(OP_MUL, 32'd7, 32'd6);
      for (int k = 1; k <= 12; k++) begin
         if (done_o) begin
            if (nd < 2) begin
               dk[nd] = k;
               dr[nd] = result_o;
            end
            nd++;
         end
         start_i = (k == 4);
         if (k == 4) begin
            op_i  = OP_MULHU;
            rs1_i = 32'hFFFF_FFFF;
            rs2_i = 32'hFFFF_FFFF;
         end
         @(negedge clk);
      end
      check("b2b done pulses", nd, 32'd2);
      check("b2b first done cycle", dk[0], 32'd4);
      check("b2b second done cycle", dk[1], 32'd9);
      check("b2b first result", dr[0], 32'h0000_002A);
      check("b2b second result", dr[1], 32'hFFFF_FFFE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
